// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a ready
// handshake, parks a completed word while stalled, and redirects after one delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_read_enable,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [31:0] if_register_pc_read_data,
  output logic [31:0] if_instruction,
  output logic        stall_request
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] hold_buf_r, hold_buf_next_s;
  logic        pend_valid_r, pend_valid_next_s;
  logic [31:0] pend_target_r, pend_target_next_s;
  logic        word_valid_s;
  logic        advance_s;
  logic [31:0] branch_addr_s;
  logic        unused_stall_s;

  // Only stall[0] concerns this stage; the rest of the vector belongs to later stages.
  assign unused_stall_s = ^stall[5:1];
  assign branch_addr_s  = {branch_target[31:2], 2'b00};

  // Advance decision and next-PC selection (branch beats pending redirect beats pc+4).
  always_comb begin
    word_valid_s = 1'b0;
    advance_s    = 1'b0;
    pc_next_s    = pc_r;
    if (state_r == FETCH) begin
      word_valid_s = mem_ready;
    end else begin
      word_valid_s = 1'b1;
    end
    advance_s = word_valid_s && !stall[0];
    if (advance_s) begin
      if (branch_flag) begin
        pc_next_s = branch_addr_s;
      end else if (pend_valid_r) begin
        pc_next_s = pend_target_r;
      end else begin
        pc_next_s = pc_r + 32'd4;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // State, hold buffer and pending-branch next values.
  always_comb begin
    state_next_s       = state_r;
    hold_buf_next_s    = hold_buf_r;
    pend_valid_next_s  = pend_valid_r;
    pend_target_next_s = pend_target_r;
    case (state_r)
      FETCH: begin
        if (mem_ready && stall[0]) begin
          // Park the completed word so it is never requested a second time.
          state_next_s    = HOLD;
          hold_buf_next_s = mem_read_data;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (!stall[0]) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
    if (advance_s) begin
      pend_valid_next_s = 1'b0;
    end else if (branch_flag) begin
      pend_valid_next_s  = 1'b1;
      pend_target_next_s = branch_addr_s;
    end else begin
      pend_valid_next_s = pend_valid_r;
    end
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      hold_buf_r    <= 32'h0000_0000;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      hold_buf_r    <= hold_buf_next_s;
      pend_valid_r  <= pend_valid_next_s;
      pend_target_r <= pend_target_next_s;
    end
  end

  // IF-side outputs; everything is forced low while reset is asserted.
  always_comb begin
    mem_read_enable          = 1'b0;
    mem_address              = 32'h0000_0000;
    if_register_pc_read_data = 32'h0000_0000;
    if_instruction           = 32'h0000_0000;
    stall_request            = 1'b0;
    if (reset) begin
      mem_address              = pc_r;
      if_register_pc_read_data = pc_r;
      case (state_r)
        FETCH: begin
          mem_read_enable = 1'b1;
          if (mem_ready) begin
            if_instruction = mem_read_data;
            stall_request  = 1'b0;
          end else begin
            if_instruction = NOP_WORD;
            stall_request  = 1'b1;
          end
        end
        HOLD: begin
          if_instruction = hold_buf_r;
        end
        default: begin
          if_instruction = NOP_WORD;
        end
      endcase
    end else begin
      mem_read_enable = 1'b0;
      stall_request   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: per-cycle input/expected-output
// records plus a check that a parked word is read from memory only once.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic [31:0] if_register_pc_read_data;
  logic [31:0] if_instruction;
  logic        stall_request;

  int n_vec = 0;
  int n_err = 0;
  int reads12 = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        bf;
    logic [31:0] bt;
    logic        rdy;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_sreq;
  } vec_t;

  vec_t vq[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .mem_read_enable(mem_read_enable),
    .mem_address(mem_address),
    .mem_read_data(mem_read_data),
    .mem_ready(mem_ready),
    .if_register_pc_read_data(if_register_pc_read_data),
    .if_instruction(if_instruction),
    .stall_request(stall_request)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory returns a recognisable word only for an active request.
  assign mem_read_data = mem_read_enable ? w(mem_address) : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (reset && mem_read_enable && mem_ready && mem_address == 32'd12) reads12 <= reads12 + 1;
  end

  task automatic add(input logic rst, input logic stl, input logic bf, input logic [31:0] bt,
                     input logic rdy, input logic e_ren, input logic [31:0] e_pc,
                     input logic [31:0] e_ins, input logic e_sreq);
    vec_t v;
    v.rst = rst; v.stl = stl; v.bf = bf; v.bt = bt; v.rdy = rdy;
    v.e_ren = e_ren; v.e_addr = e_pc; v.e_pc = e_pc; v.e_ins = e_ins; v.e_sreq = e_sreq;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b0; stall = 6'b0; branch_flag = 1'b0; branch_target = 32'h0; mem_ready = 1'b1;

    // rst stl bf target rdy | ren pc ins sreq
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);           // 0 reset
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);           // 1 reset
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, w(32'h0), 1'b0);        // 2 pc0
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, w(32'h4), 1'b0);        // 3 pc4
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1);           // 4 wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1);           // 5 wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1);           // 6 wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, w(32'h8), 1'b0);        // 7 word(8)
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, w(32'hC), 1'b0);        // 8 ->HOLD
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, w(32'hC), 1'b0);        // 9 HOLD
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, w(32'hC), 1'b0);        // 10 HOLD release
    add(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h10, w(32'h10), 1'b0);    // 11 delay slot
    add(1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 32'h100, w(32'h100), 1'b0);  // 12 misaligned
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, w(32'h100), 1'b0);    // 13
    add(1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h104, w(32'h104), 1'b0);   // 14 go to 20
    add(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h14, 32'h0, 1'b1);        // 15 pend
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 32'h0, 1'b1);          // 16 wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, w(32'h14), 1'b0);      // 17 word(20)
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, w(32'h200), 1'b0);    // 18 pend target
    add(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h204, 32'h0, 1'b1);       // 19 pend 300
    add(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h204, 32'h0, 1'b1);       // 20 overwrite
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, w(32'h204), 1'b0);    // 21
    add(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h400, w(32'h400), 1'b0); // 22
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 1'b0); // 23 wrap
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, w(32'h0), 1'b0);        // 24
    add(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h4, 32'h0, 1'b1);          // 25 pend 80
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);           // 26 reset mid-wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, w(32'h0), 1'b0);        // 27 RESET_PC
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, w(32'h4), 1'b0);        // 28 pend gone
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1);           // 29 stall+wait
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, w(32'h8), 1'b0);        // 30
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, w(32'hC), 1'b0);        // 31

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; stall = {5'b0, vq[i].stl}; branch_flag = vq[i].bf;
      branch_target = vq[i].bt; mem_ready = vq[i].rdy;
      #1;
      n_vec = n_vec + 1;
      if (mem_read_enable !== vq[i].e_ren || mem_address !== vq[i].e_addr ||
          if_register_pc_read_data !== vq[i].e_pc || if_instruction !== vq[i].e_ins ||
          stall_request !== vq[i].e_sreq) begin
        n_err = n_err + 1;
        $display("FAIL vec%0d: got ren=%b addr=%h pc=%h ins=%h sreq=%b, want ren=%b addr=%h pc=%h ins=%h sreq=%b",
                 i, mem_read_enable, mem_address, if_register_pc_read_data, if_instruction, stall_request,
                 vq[i].e_ren, vq[i].e_addr, vq[i].e_pc, vq[i].e_ins, vq[i].e_sreq);
      end
      @(posedge clock);
      #1;
    end

    // The parked word at address 12 must have been requested exactly once
    // (address 12 is visited twice in the table: once parked, once at the end).
    n_vec = n_vec + 1;
    if (reads12 != 2) begin
      n_err = n_err + 1;
      $display("FAIL reads12: got %0d completed reads of address 12, want 2", reads12);
    end

    // HOLD sequence again by hand: branch arriving while parked becomes pending.
    reset = 1'b1; stall = 6'b000001; branch_flag = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;                         // pc 16 parked in HOLD
    branch_flag = 1'b1; branch_target = 32'h0000_0800;
    @(posedge clock); #1;                         // non-advancing edge captures pend
    branch_flag = 1'b0; stall = 6'b000000;
    #1;
    n_vec = n_vec + 1;
    if (mem_read_enable !== 1'b0 || if_instruction !== w(32'h10) || if_register_pc_read_data !== 32'h10) begin
      n_err = n_err + 1;
      $display("FAIL hold16: got ren=%b ins=%h pc=%h, want ren=0 ins=%h pc=00000010",
               mem_read_enable, if_instruction, if_register_pc_read_data, w(32'h10));
    end
    @(posedge clock); #1;
    n_vec = n_vec + 1;
    if (mem_address !== 32'h800 || mem_read_enable !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL hold_pend: got addr=%h ren=%b, want addr=00000800 ren=1", mem_address, mem_read_enable);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
